// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one external 32-bit ALU between two valid/ready requesters, one op in flight.
// Build option: define ALU_ARB_FIXED_PRIO_EN for fixed priority (req0 wins); default is round-robin.
module alu_arbiter #(
  parameter int WIDTH = 32,
  parameter int OPW   = 3
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [1:0]         req_valid,
  output logic [1:0]         req_ready,
  input  logic [2*WIDTH-1:0] req_a,
  input  logic [2*WIDTH-1:0] req_b,
  input  logic [2*OPW-1:0]   req_op,
  output logic               resp_valid,
  input  logic               resp_ready,
  output logic               resp_id,
  output logic [WIDTH-1:0]   resp_c,
  output logic               resp_err,
  output logic [WIDTH-1:0]   alu_a,
  output logic [WIDTH-1:0]   alu_b,
  output logic [OPW-1:0]     alu_op,
  input  logic [WIDTH-1:0]   alu_c
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_EXEC = 2'b01,
    ST_RESP = 2'b10
  } state_t;

  state_t             state_r;
  state_t             state_s;
  logic               grant_s;
  logic               grant_id_s;
  logic [WIDTH-1:0]   sel_a_s;
  logic [WIDTH-1:0]   sel_b_s;
  logic [OPW-1:0]     sel_op_s;
  logic               id_r;
  logic [WIDTH-1:0]   alu_a_r;
  logic [WIDTH-1:0]   alu_b_r;
  logic [OPW-1:0]     alu_op_r;
  logic               resp_valid_r;
  logic               resp_id_r;
  logic [WIDTH-1:0]   resp_c_r;
  logic               resp_err_r;
`ifndef ALU_ARB_FIXED_PRIO_EN
  logic               last_grant_r;
`endif

  // Encodings 110/111 have no ALU function; their result is forced to zero and flagged.
  function automatic logic op_invalid(input logic [OPW-1:0] op);
    return (op[OPW-1:OPW-2] == 2'b11);
  endfunction

  // Arbitration: only in IDLE and never while reset is asserted.
  always_comb begin
    grant_s    = 1'b0;
    grant_id_s = 1'b0;
    if ((state_r == ST_IDLE) && !reset) begin
      case (req_valid)
        2'b01: begin
          grant_s    = 1'b1;
          grant_id_s = 1'b0;
        end
        2'b10: begin
          grant_s    = 1'b1;
          grant_id_s = 1'b1;
        end
        2'b11: begin
          grant_s    = 1'b1;
`ifdef ALU_ARB_FIXED_PRIO_EN
          grant_id_s = 1'b0;
`else
          grant_id_s = ~last_grant_r;
`endif
        end
        default: begin
          grant_s    = 1'b0;
          grant_id_s = 1'b0;
        end
      endcase
    end else begin
      grant_s    = 1'b0;
      grant_id_s = 1'b0;
    end
  end

  // Accept strobe and operand mux for the granted requester.
  always_comb begin
    req_ready = 2'b00;
    sel_a_s   = req_a[WIDTH-1:0];
    sel_b_s   = req_b[WIDTH-1:0];
    sel_op_s  = req_op[OPW-1:0];
    if (grant_id_s) begin
      sel_a_s  = req_a[2*WIDTH-1:WIDTH];
      sel_b_s  = req_b[2*WIDTH-1:WIDTH];
      sel_op_s = req_op[2*OPW-1:OPW];
    end else begin
      sel_a_s  = req_a[WIDTH-1:0];
      sel_b_s  = req_b[WIDTH-1:0];
      sel_op_s = req_op[OPW-1:0];
    end
    if (grant_s) begin
      req_ready = grant_id_s ? 2'b10 : 2'b01;
    end else begin
      req_ready = 2'b00;
    end
  end

  // Next-state logic: IDLE -> EXEC -> RESP -> IDLE.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (grant_s) begin
          state_s = ST_EXEC;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_EXEC: begin
        state_s = ST_RESP;
      end
      ST_RESP: begin
        if (resp_ready) begin
          state_s = ST_IDLE;
        end else begin
          state_s = ST_RESP;
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // State register and response valid flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r      <= ST_IDLE;
      resp_valid_r <= 1'b0;
    end else begin
      state_r      <= state_s;
      resp_valid_r <= (state_s == ST_RESP);
    end
  end

  // Operand registers double as the ALU drive, so the ALU inputs hold outside EXEC.
  always_ff @(posedge clk) begin
    if (reset) begin
      alu_a_r  <= {WIDTH{1'b0}};
      alu_b_r  <= {WIDTH{1'b0}};
      alu_op_r <= {OPW{1'b0}};
      id_r     <= 1'b0;
    end else if (grant_s) begin
      alu_a_r  <= sel_a_s;
      alu_b_r  <= sel_b_s;
      alu_op_r <= sel_op_s;
      id_r     <= grant_id_s;
    end
  end

`ifndef ALU_ARB_FIXED_PRIO_EN
  // Round-robin history; reset value 1 lets req0 win the first contention.
  always_ff @(posedge clk) begin
    if (reset) begin
      last_grant_r <= 1'b1;
    end else if (grant_s) begin
      last_grant_r <= grant_id_s;
    end
  end
`endif

  // Result capture: the ALU output is only meaningful during EXEC.
  always_ff @(posedge clk) begin
    if (reset) begin
      resp_id_r  <= 1'b0;
      resp_c_r   <= {WIDTH{1'b0}};
      resp_err_r <= 1'b0;
    end else if (state_r == ST_EXEC) begin
      resp_id_r  <= id_r;
      resp_c_r   <= op_invalid(alu_op_r) ? {WIDTH{1'b0}} : alu_c;
      resp_err_r <= op_invalid(alu_op_r);
    end
  end

  assign resp_valid = resp_valid_r;
  assign resp_id    = resp_id_r;
  assign resp_c     = resp_c_r;
  assign resp_err   = resp_err_r;
  assign alu_a      = alu_a_r;
  assign alu_b      = alu_b_r;
  assign alu_op     = alu_op_r;

endmodule
